spi_flash_rd_ctrl: RTL and testbench
====================================

// Module: spi_flash_rd_ctrl
// PURPOSE
//  SPI master that reads a block of bytes from an M25P16-class serial flash when triggered.
//  - A one-cycle key_flag pulse starts a READ (0x03) + 24-bit address transaction.
//  - It reads DATA_NUM bytes into an internal buffer.
//  - It then replays the bytes one at a time on pi_data/pi_flag, paced for a UART-style consumer.
//  - Sits between the key debouncer and the UART transmitter in the flash read demo.
// PARAMETERS
//  READ_ADDR  24'h000000  start byte address (sector/page/byte), sent MSB first
//  DATA_NUM   100         bytes read per trigger (1..128)
//  WAIT_MAX   5000        sys_clk cycles between successive pi_flag pulses (>=2)
// PORTS
//  sys_clk    in   1  system clock (50 MHz)
//  sys_rst    in   1  asynchronous reset, active-high
//  key_flag   in   1  one-cycle start pulse
//  miso       in   1  flash serial data out
//  sck        out  1  SPI clock, mode 0, sys_clk/4
//  cs_n       out  1  flash chip select, active-low
//  mosi       out  1  flash serial data in
//  pi_data    out  8  replayed byte
//  pi_flag    out  1  one-cycle strobe, pi_data valid
// BEHAVIOUR
//  - Reset: outputs sck=0, cs_n=1, mosi=0, pi_data=0, pi_flag=0.
//  - Reset: all counters cleared, FSM=IDLE, read buffer contents don't-care.
//  - FSM states:
//    - IDLE -> SEND on key_flag.
//    - SEND -> RECV after 32 bits.
//    - RECV -> OUT after DATA_NUM*8 bits; cs_n goes 1 here.
//    - OUT -> IDLE after DATA_NUM strobes.
//  - key_flag is ignored outside IDLE.
//  - cs_n falls in the cycle after key_flag and stays low through SEND and RECV.
//  - Bit timing: each SPI bit is 4 sys_clk phases, cnt 0..3.
//    - sck=0 in phases 0-1, sck=1 in phases 2-3.
//    - mosi updates in phase 0; miso is sampled at the end of phase 2 (sck rising edge).
//  - SEND shifts {8'h03, READ_ADDR} MSB first. mosi=0 during RECV and while idle.
//  - RECV assembles bytes MSB first and writes byte k to buffer[k] after its 8th bit.
//  - OUT: a wait counter counts 0..WAIT_MAX-1.
//    - At count WAIT_MAX-1, pi_data <= buffer[idx] and pi_flag=1 for exactly one cycle.
//    - Then idx increments.
//    - First strobe comes WAIT_MAX cycles after entering OUT.
//    - pi_data holds its value between strobes.
//  - After the last strobe: return to IDLE; a new key_flag restarts a full transaction.
//  - Reset mid-transaction: cs_n returns to 1 immediately (async); no partial output is emitted.
//  - Address wrap past 24'hFFFFFF is handled by the flash; the controller does not check it.
// CONFIGURATION
//  FLASH_FAST_READ_EN
//  - Defined: SEND shifts {8'h0B, READ_ADDR, 8'h00}, 40 bits including the dummy byte, then RECV.
//  - Undefined: standard READ 0x03, 32-bit header.
//  - Bit timing and the output phase are identical in both builds.
// TESTING
//  - Reset: sys_rst=1 for 30 ns -> cs_n=1, sck=0, pi_flag=0 throughout.
//  - Trigger, WAIT_MAX=100:
//    - key_flag pulse at 1030 ns -> cs_n low next cycle.
//    - mosi shows 0x03 then 0x000000 over 128 sys_clk.
//    - sck is a 12.5 MHz square wave.
//  - Read data: flash preloaded with bytes 0x00,0x01,...
//    - DATA_NUM pi_flag pulses spaced exactly 100 cycles apart.
//    - pi_data = 0x00,0x01,... in order.
//    - cs_n=1 before the first pulse.
//  - Busy trigger: key_flag re-pulsed during RECV -> ignored; exactly DATA_NUM pulses total.
//  - Reset mid-RECV -> cs_n=1 and sck=0 at once; no pi_flag until a new key_flag.
//  - FLASH_FAST_READ_EN build: mosi header 0x0B,0x000000,0x00; same pi_data sequence.

Source files
------------

// File: rtl/spi_flash_rd_ctrl.sv
// SPI master that reads DATA_NUM bytes from an M25P16-class flash on key_flag, then replays them on pi_data/pi_flag.
// Optional build macro FLASH_FAST_READ_EN selects FAST_READ (0x0B + address + dummy byte) instead of READ (0x03).
module spi_flash_rd_ctrl #(
    parameter logic [23:0]  READ_ADDR = 24'h000000,
    parameter int unsigned  DATA_NUM  = 100,
    parameter int unsigned  WAIT_MAX  = 5000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_flag,
    input  logic       miso,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    output logic [7:0] pi_data,
    output logic       pi_flag
);

`ifdef FLASH_FAST_READ_EN
    localparam int unsigned          HDR_BITS = 40;
    localparam logic [HDR_BITS-1:0]  HDR      = {8'h0B, READ_ADDR, 8'h00};
`else
    localparam int unsigned          HDR_BITS = 32;
    localparam logic [HDR_BITS-1:0]  HDR      = {8'h03, READ_ADDR};
`endif

    localparam int unsigned RX_BITS = DATA_NUM * 8;
    localparam int unsigned BIT_W   = $clog2((RX_BITS > HDR_BITS) ? RX_BITS : HDR_BITS);
    localparam int unsigned IDX_W   = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int unsigned WAIT_W  = $clog2(WAIT_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [HDR_BITS-1:0] hdr_sr;
    logic [6:0]          rx_sr;
    logic [IDX_W-1:0]    idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          buffer [DATA_NUM];

    logic                buf_we_c;
    logic [IDX_W-1:0]    buf_addr_c;
    logic [7:0]          rx_byte_c;

    // A byte completes when its 8th bit is sampled at the sck rising-edge phase.
    assign rx_byte_c  = {rx_sr, miso};
    assign buf_we_c   = (state == RECV) && (cnt == 2'd2) && (bit_cnt[2:0] == 3'd7);
    assign buf_addr_c = IDX_W'(bit_cnt >> 3);

    always_ff @(posedge sys_clk) begin
        if (buf_we_c) begin
            buffer[buf_addr_c] <= rx_byte_c;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            bit_cnt  <= '0;
            hdr_sr   <= '0;
            rx_sr    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            pi_data  <= 8'h00;
            pi_flag  <= 1'b0;
        end else begin
            pi_flag <= 1'b0;

            // Four phases per SPI bit: sck low in 0-1, high in 2-3.
            if (state == SEND || state == RECV) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd1) begin
                    sck <= 1'b1;
                end else if (cnt == 2'd3) begin
                    sck <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (key_flag) begin
                        state   <= SEND;
                        cs_n    <= 1'b0;
                        cnt     <= 2'd0;
                        bit_cnt <= '0;
                        mosi    <= HDR[HDR_BITS-1];
                        hdr_sr  <= HDR << 1;
                    end
                end
                SEND: begin
                    if (cnt == 2'd3) begin
                        if (bit_cnt == BIT_W'(HDR_BITS - 1)) begin
                            state   <= RECV;
                            bit_cnt <= '0;
                            mosi    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            mosi    <= hdr_sr[HDR_BITS-1];
                            hdr_sr  <= hdr_sr << 1;
                        end
                    end
                end
                RECV: begin
                    if (cnt == 2'd2) begin
                        rx_sr <= rx_byte_c[6:0];
                    end
                    if (cnt == 2'd3) begin
                        if (bit_cnt == BIT_W'(RX_BITS - 1)) begin
                            state    <= OUT;
                            cs_n     <= 1'b1;
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
                            idx      <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                        wait_cnt <= '0;
                        pi_flag  <= 1'b1;
                        pi_data  <= buffer[idx];
                        if (idx == IDX_W'(DATA_NUM - 1)) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: behavioural flash model on the SPI pins plus a replay reference.
// Honours FLASH_FAST_READ_EN the same way as the design.
module tb_spi_flash_rd_ctrl;

    localparam logic [23:0] ADDR  = 24'hA53C0F;
    localparam int          DNUM  = 16;
    localparam int          WMAX  = 100;
`ifdef FLASH_FAST_READ_EN
    localparam int          HBITS = 40;
`else
    localparam int          HBITS = 32;
`endif
    localparam int          BUDGET = 4 * HBITS + 32 * DNUM + WMAX * DNUM + 1000;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_flag = 1'b0;
    logic       miso = 1'b0;
    logic       sck, cs_n, mosi, pi_flag;
    logic [7:0] pi_data;

    int checks = 0;
    int failures = 0;

    spi_flash_rd_ctrl #(.READ_ADDR(ADDR), .DATA_NUM(DNUM), .WAIT_MAX(WMAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag), .miso(miso),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .pi_data(pi_data), .pi_flag(pi_flag)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Flash model: 256-byte window of content, address taken from the captured header.
    logic [7:0]  mem [256];
    logic [39:0] hdr_cap = '0;
    int          rx_cnt = 0;
    int          mosi_err = 0;
    logic [7:0]  cap_lo;
`ifdef FLASH_FAST_READ_EN
    assign cap_lo = hdr_cap[15:8];
`else
    assign cap_lo = hdr_cap[7:0];
`endif

    always @(negedge cs_n) begin
        rx_cnt  = 0;
        hdr_cap = '0;
    end

    always @(posedge sck) begin
        if (cs_n === 1'b0) begin
            if (rx_cnt < HBITS) hdr_cap = {hdr_cap[38:0], mosi};
            else if (mosi !== 1'b0) mosi_err++;
            rx_cnt++;
        end
    end

    always @(negedge sck) begin : flash_tx
        int         t;
        logic [7:0] a;
        logic [7:0] b;
        if (cs_n === 1'b0 && rx_cnt >= HBITS) begin
            t = rx_cnt - HBITS;
            a = cap_lo + 8'(t / 8);
            b = mem[a] << 3'(t % 8);
            miso = b[7];
        end
    end

    // Output-side monitor, sampled away from the active edge.
    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];
    int         csn_rise_cyc = -1;
    int         last_rise = -1;
    int         sck_err = 0;
    int         hold_err = 0;
    logic       prev_cs = 1'b1;
    logic       prev_sck = 1'b0;
    logic [7:0] prev_pd = 8'h00;

    always @(negedge sys_clk) begin
        if (pi_flag === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(pi_data);
        end else if (!sys_rst && pi_data !== prev_pd) begin
            hold_err++;
        end
        if (cs_n === 1'b1 && prev_cs === 1'b0) csn_rise_cyc = cyc;
        if (cs_n === 1'b1) begin
            last_rise = -1;
            if (sck !== 1'b0) sck_err++;
        end else if (sck === 1'b1 && prev_sck === 1'b0) begin
            if (last_rise >= 0 && cyc - last_rise != 4) sck_err++;
            last_rise = cyc;
        end
        prev_cs  = cs_n;
        prev_sck = sck;
        prev_pd  = pi_data;
    end

    task automatic pulse_key();
        @(posedge sys_clk); #1 key_flag = 1'b1;
        @(posedge sys_clk); #1 key_flag = 1'b0;
    endtask

    task automatic clear_monitor();
        pulse_cyc.delete();
        pulse_data.delete();
        csn_rise_cyc = -1;
        sck_err = 0;
        mosi_err = 0;
        hold_err = 0;
    endtask

    task automatic start_read(input bit incr);
        for (int i = 0; i < 256; i++) mem[i] = incr ? 8'(i) : 8'($urandom);
        clear_monitor();
        repeat ($urandom_range(1, 20)) @(posedge sys_clk);
        pulse_key();
        checks++;
        if (cs_n !== 1'b0) begin
            failures++;
            $display("FAIL csn_fall: cs_n=%b expected 0 one cycle after key_flag", cs_n);
        end
    endtask

    task automatic finish_read(input string name);
        int          n = 0;
        logic [23:0] addr_v = ADDR;
        logic [39:0] exp_hdr;
        logic [7:0]  exp_b;
`ifdef FLASH_FAST_READ_EN
        exp_hdr = {8'h0B, addr_v, 8'h00};
`else
        exp_hdr = 40'({8'h03, addr_v});
`endif
        while (pulse_cyc.size() < DNUM && n < BUDGET) begin
            @(posedge sys_clk);
            n++;
        end
        repeat (2 * WMAX) @(posedge sys_clk);
        #1;
        checks++;
        if (hdr_cap !== exp_hdr) begin
            failures++;
            $display("FAIL %s header: got %h expected %h", name, hdr_cap, exp_hdr);
        end
        checks++;
        if (pulse_cyc.size() != DNUM) begin
            failures++;
            $display("FAIL %s pulse_count: got %0d expected %0d", name, pulse_cyc.size(), DNUM);
        end
        for (int k = 0; k < DNUM && k < pulse_cyc.size(); k++) begin
            exp_b = mem[8'(addr_v[7:0] + 8'(k))];
            checks++;
            if (pulse_data[k] !== exp_b) begin
                failures++;
                $display("FAIL %s data[%0d]: got %h expected %h", name, k, pulse_data[k], exp_b);
            end
            if (k > 0) begin
                checks++;
                if (pulse_cyc[k] - pulse_cyc[k-1] != WMAX) begin
                    failures++;
                    $display("FAIL %s spacing[%0d]: got %0d expected %0d", name, k,
                             pulse_cyc[k] - pulse_cyc[k-1], WMAX);
                end
            end
        end
        if (pulse_cyc.size() > 0) begin
            checks++;
            if (csn_rise_cyc < 0 || pulse_cyc[0] - csn_rise_cyc != WMAX) begin
                failures++;
                $display("FAIL %s first_latency: got %0d expected %0d", name,
                         pulse_cyc[0] - csn_rise_cyc, WMAX);
            end
        end
        checks++;
        if (sck_err != 0 || mosi_err != 0 || hold_err != 0 || cs_n !== 1'b1) begin
            failures++;
            $display("FAIL %s pins: sck_err=%0d mosi_err=%0d hold_err=%0d cs_n=%b expected 0/0/0/1",
                     name, sck_err, mosi_err, hold_err, cs_n);
        end
    endtask

    task automatic wait_recv(input int bits, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < BUDGET && !(rx_cnt > HBITS + bits && sck === 1'b1 && cs_n === 1'b0)) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (rx_cnt > HBITS + bits) && (sck === 1'b1);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_recv: timeout rx_cnt=%0d expected > %0d", rx_cnt, HBITS + bits);
        end
    endtask

    task automatic test_reset();
        #25;
        checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || pi_flag !== 1'b0 || pi_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_values: cs_n=%b sck=%b mosi=%b pi_flag=%b pi_data=%h expected 1/0/0/0/00",
                     cs_n, sck, mosi, pi_flag, pi_data);
        end
        #6 sys_rst = 1'b0;
        clear_monitor();
        repeat (30) @(posedge sys_clk);
        #1;
        checks++;
        if (cs_n !== 1'b1 || pulse_cyc.size() != 0 || sck_err != 0) begin
            failures++;
            $display("FAIL reset_idle: cs_n=%b pulses=%0d sck_err=%0d expected 1/0/0",
                     cs_n, pulse_cyc.size(), sck_err);
        end
    endtask

    task automatic test_read_incr();
        start_read(1'b1);
        finish_read("read_incr");
    endtask

    task automatic test_read_random();
        start_read(1'b0);
        finish_read("read_random");
    endtask

    task automatic test_busy_trigger();
        bit ok;
        start_read(1'b0);
        wait_recv(40, ok);
        pulse_key();
        finish_read("busy_trigger");
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_read(1'b0);
        wait_recv(24, ok);
        #3 sys_rst = 1'b1;
        #1;
        checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: cs_n=%b sck=%b expected 1/0", cs_n, sck);
        end
        #20 sys_rst = 1'b0;
        clear_monitor();
        repeat (32 * DNUM + WMAX * (DNUM + 2)) @(posedge sys_clk);
        #1;
        checks++;
        if (pulse_cyc.size() != 0 || cs_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_quiet: pulses=%0d cs_n=%b expected 0/1", pulse_cyc.size(), cs_n);
        end
    endtask

    task automatic test_back_to_back();
        start_read(1'b0);
        finish_read("back_to_back_a");
        start_read(1'b0);
        finish_read("back_to_back_b");
    endtask

    initial begin
        test_reset();
        test_read_incr();
        test_read_random();
        test_busy_trigger();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
